cmp_debounce: RTL and testbench

Registered, debouncing consumer of the N-bit comparator's one-hot result (`Ls`/`Gr`/`Eq`), placed directly downstream of it. It qualifies the relation over `DEBOUNCE` consecutive valid samples before accepting it as the stable relation. Each change of the stable relation is posted as an event through a single-entry valid/ready output buffer, with sticky flags for overflow and malformed input.

---
 rtl/cmp_debounce.sv | 139 +++++++++++++
 tb/tb_cmp_debounce.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cmp_debounce.sv
// cmp_debounce: debounces the comparator's one-hot Ls/Gr/Eq result and posts each
// change of the stable relation through a single-entry valid/ready event buffer.
module cmp_debounce #(
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       ls,
  input  logic       gr,
  input  logic       eq,
  output logic [1:0] state_o,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       ovf,
  output logic       err
);

  localparam logic [1:0] REL_UNKNOWN = 2'b00;
  localparam logic [1:0] REL_LESS    = 2'b01;
  localparam logic [1:0] REL_GREATER = 2'b10;
  localparam logic [1:0] REL_EQUAL   = 2'b11;

  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             evt_valid_q, evt_valid_d;
  logic [1:0]       evt_code_q, evt_code_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [1:0]       sample_rel;
  logic             sample_onehot;
  logic             sample_good;
  logic             sample_bad;
  logic             qualify;
  logic             accept;

  // Decode the comparator flags into a relation code and a one-hot indication.
  always_comb begin
    sample_rel    = REL_UNKNOWN;
    sample_onehot = 1'b0;
    case ({ls, gr, eq})
      3'b100: begin
        sample_rel    = REL_LESS;
        sample_onehot = 1'b1;
      end
      3'b010: begin
        sample_rel    = REL_GREATER;
        sample_onehot = 1'b1;
      end
      3'b001: begin
        sample_rel    = REL_EQUAL;
        sample_onehot = 1'b1;
      end
      default: begin
        sample_rel    = REL_UNKNOWN;
        sample_onehot = 1'b0;
      end
    endcase
    sample_good = in_valid && sample_onehot;
    sample_bad  = in_valid && !sample_onehot;
  end

  // Run tracking: extend or restart the candidate run; a malformed sample wipes it.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (sample_good) begin
      if (sample_rel == cand_q) begin
        cnt_d = (cnt_q < CNT_TARGET) ? cnt_q + CNT_ONE : CNT_TARGET;
      end else begin
        cand_d = sample_rel;
        cnt_d  = CNT_ONE;
      end
    end else if (sample_bad) begin
      err_d  = 1'b1;
      cand_d = REL_UNKNOWN;
      cnt_d  = '0;
    end
  end

  // Qualification: a completed run of a relation different from the stable one.
  always_comb begin
    qualify = sample_good && (cnt_d == CNT_TARGET) && (cand_d != state_q);
    state_d = qualify ? cand_d : state_q;
  end

  // Single-entry event buffer; a post onto an unaccepted entry overwrites it and flags ovf.
  always_comb begin
    accept      = evt_valid_q && evt_ready;
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    ovf_d       = ovf_q;
    if (qualify) begin
      evt_valid_d = 1'b1;
      evt_code_d  = cand_d;
      if (evt_valid_q && !evt_ready) begin
        ovf_d = 1'b1;
      end
    end else if (accept) begin
      evt_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= REL_UNKNOWN;
      cand_q      <= REL_UNKNOWN;
      cnt_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= REL_UNKNOWN;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign state_o   = state_q;
  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cmp_debounce.sv
// Directed self-checking bench for cmp_debounce with DEBOUNCE=3.
module tb_cmp_debounce;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       ls, gr, eq;
  logic [1:0] state_o;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;
  logic       ovf;
  logic       err;

  int n_vec;
  int n_err;

  cmp_debounce #(.DEBOUNCE(3), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .ls        (ls),
    .gr        (gr),
    .eq        (eq),
    .state_o   (state_o),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ready (evt_ready),
    .ovf       (ovf),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge, then settle just past the rising edge.
  task automatic step(input logic iv, input logic [2:0] lge, input logic rdy);
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = iv;
    {ls, gr, eq} = lge;
    evt_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    {ls, gr, eq} = 3'b000;
    evt_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (state_o !== 2'b00) begin n_err++; $display("FAIL reset_state: got %b want 00", state_o); end
    n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL reset_evt_valid: got %b want 0", evt_valid); end
    n_vec++; if (evt_code !== 2'b00) begin n_err++; $display("FAIL reset_evt_code: got %b want 00", evt_code); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_qualify();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'b010, 1'b1);
      n_vec++; if (state_o !== ((i == 2) ? 2'b10 : 2'b00)) begin n_err++; $display("FAIL qual_state[%0d]: got %b want %b", i, state_o, (i == 2) ? 2'b10 : 2'b00); end
      n_vec++; if (evt_valid !== (i == 2)) begin n_err++; $display("FAIL qual_evt_valid[%0d]: got %b want %b", i, evt_valid, i == 2); end
    end
    n_vec++; if (evt_code !== 2'b10) begin n_err++; $display("FAIL qual_evt_code: got %b want 10", evt_code); end
    // Event is accepted on the first of these edges; saturated run must not re-post.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'b010, 1'b1);
      n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL sat_evt_valid[%0d]: got %b want 0", i, evt_valid); end
      n_vec++; if (state_o !== 2'b10) begin n_err++; $display("FAIL sat_state[%0d]: got %b want 10", i, state_o); end
    end
  endtask

  task automatic test_restart();
    logic [2:0] seq [6];
    seq = '{3'b100, 3'b100, 3'b010, 3'b100, 3'b100, 3'b100};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, seq[i], 1'b1);
      n_vec++; if (state_o !== ((i == 5) ? 2'b01 : 2'b10)) begin n_err++; $display("FAIL restart_state[%0d]: got %b want %b", i, state_o, (i == 5) ? 2'b01 : 2'b10); end
      n_vec++; if (evt_valid !== (i == 5)) begin n_err++; $display("FAIL restart_evt_valid[%0d]: got %b want %b", i, evt_valid, i == 5); end
    end
    n_vec++; if (evt_code !== 2'b01) begin n_err++; $display("FAIL restart_evt_code: got %b want 01", evt_code); end
    step(1'b0, 3'b000, 1'b1);
    n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL restart_accept: got %b want 0", evt_valid); end
  endtask

  task automatic test_gaps();
    step(1'b1, 3'b001, 1'b1);
    step(1'b1, 3'b001, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 3'b000, 1'b1);
      n_vec++; if (state_o !== 2'b01) begin n_err++; $display("FAIL gap_state[%0d]: got %b want 01", i, state_o); end
      n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL gap_evt_valid[%0d]: got %b want 0", i, evt_valid); end
    end
    step(1'b1, 3'b001, 1'b1);
    n_vec++; if (state_o !== 2'b11) begin n_err++; $display("FAIL gap_final_state: got %b want 11", state_o); end
    n_vec++; if (evt_valid !== 1'b1 || evt_code !== 2'b11) begin n_err++; $display("FAIL gap_evt: got %b/%b want 1/11", evt_valid, evt_code); end
    step(1'b0, 3'b000, 1'b1);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) step(1'b1, 3'b100, 1'b0);
    n_vec++; if (evt_valid !== 1'b1 || evt_code !== 2'b01) begin n_err++; $display("FAIL ovf_first_evt: got %b/%b want 1/01", evt_valid, evt_code); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", ovf); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'b010, 1'b0);
      n_vec++; if (evt_code !== ((i == 2) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL ovf_code[%0d]: got %b want %b", i, evt_code, (i == 2) ? 2'b10 : 2'b01); end
      n_vec++; if (ovf !== (i == 2)) begin n_err++; $display("FAIL ovf_flag[%0d]: got %b want %b", i, ovf, i == 2); end
    end
    n_vec++; if (evt_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid: got %b want 1", evt_valid); end
    step(1'b0, 3'b000, 1'b1);
    n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drain: got %b want 0", evt_valid); end
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
  endtask

  task automatic test_error();
    do_reset();
    step(1'b1, 3'b001, 1'b1);
    step(1'b1, 3'b001, 1'b1);
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_early: got %b want 0", err); end
    step(1'b1, 3'b110, 1'b1);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", err); end
    n_vec++; if (dut.cnt_q !== 4'd0) begin n_err++; $display("FAIL err_cnt_clear: got %0d want 0", dut.cnt_q); end
    step(1'b1, 3'b001, 1'b1);
    n_vec++; if (dut.cnt_q !== 4'd1) begin n_err++; $display("FAIL err_cnt_restart: got %0d want 1", dut.cnt_q); end
    n_vec++; if (state_o !== 2'b00) begin n_err++; $display("FAIL err_state_hold: got %b want 00", state_o); end
    n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL err_no_evt: got %b want 0", evt_valid); end
    step(1'b1, 3'b001, 1'b1);
    n_vec++; if (state_o !== 2'b00) begin n_err++; $display("FAIL err_state_mid: got %b want 00", state_o); end
    step(1'b1, 3'b001, 1'b1);
    n_vec++; if (state_o !== 2'b11) begin n_err++; $display("FAIL err_state_final: got %b want 11", state_o); end
    n_vec++; if (evt_valid !== 1'b1 || evt_code !== 2'b11) begin n_err++; $display("FAIL err_final_evt: got %b/%b want 1/11", evt_valid, evt_code); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_midrun();
    step(1'b0, 3'b000, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 3'b100, 1'b0);
    step(1'b1, 3'b010, 1'b0);
    step(1'b1, 3'b010, 1'b0);
    n_vec++; if (evt_valid !== 1'b1 || dut.cnt_q !== 4'd2) begin n_err++; $display("FAIL mid_setup: got valid %b cnt %0d want 1/2", evt_valid, dut.cnt_q); end
    do_reset();
    n_vec++; if ({state_o, evt_valid, evt_code, ovf, err} !== 7'b0) begin n_err++; $display("FAIL mid_reset: got %b want 0000000", {state_o, evt_valid, evt_code, ovf, err}); end
    n_vec++; if (dut.cnt_q !== 4'd0) begin n_err++; $display("FAIL mid_reset_cnt: got %0d want 0", dut.cnt_q); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'b100, 1'b0);
      n_vec++; if (evt_valid !== (i == 2)) begin n_err++; $display("FAIL mid_evt_valid[%0d]: got %b want %b", i, evt_valid, i == 2); end
    end
    n_vec++; if (evt_code !== 2'b01 || state_o !== 2'b01) begin n_err++; $display("FAIL mid_final: got %b/%b want 01/01", evt_code, state_o); end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    ls        = 1'b0;
    gr        = 1'b0;
    eq        = 1'b0;
    evt_ready = 1'b0;
    test_reset();
    test_qualify();
    test_restart();
    test_gaps();
    test_overflow();
    test_error();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
